// File: rtl/torque_gen.sv
// torque_gen: counts flexor/extensor spikes per tick window, scales each count by
// GAIN through one shared multiplier, low-pass filters the result into the torque
// outputs, and then pulses torque_valid for the plant.
// Optional build macro TORQUE_GEN_SATURATE_EN: clip drive and filtered force to
// [0, 2^17-1]. Without it, drive and force wrap modulo 2^18.
module torque_gen #(
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned GAIN      = 64,
    parameter int unsigned TAU_SHIFT = 4,
    parameter int unsigned VALID_LEN = 4
) (
    input  logic                neuronClock,
    input  logic                neuronReset_n,
    input  logic                tick,
    input  logic                spike1,
    input  logic                spike2,
    output logic signed [17:0]  torque1,
    output logic signed [17:0]  torque2,
    output logic                torque_valid,
    output logic                busy,
    output logic                cnt_sat,
    output logic                overrun
);

    localparam int unsigned TW  = 18;
    localparam int unsigned PW  = 36;
    localparam int unsigned VCW = (VALID_LEN < 2) ? 1 : $clog2(VALID_LEN + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MUL1   = 2'd1;
    localparam logic [1:0] MUL2   = 2'd2;
    localparam logic [1:0] STROBE = 2'd3;

    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic signed [TW-1:0] F_MAX = 18'sh1FFFF;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [CNT_W-1:0]        lat1_q, lat1_d, lat2_q, lat2_d;
    logic signed [TW-1:0]    f1n_q, f1n_d;
    logic signed [TW-1:0]    torque1_q, torque1_d, torque2_q, torque2_d;
    logic [VCW-1:0]          vcnt_q, vcnt_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    cnt_sat_q, cnt_sat_d;
    logic                    overrun_q, overrun_d;

    logic [CNT_W-1:0]        mul_lat_c;
    logic signed [TW-1:0]    f_cur_c;
    logic [PW-1:0]           product_c;
    logic signed [TW-1:0]    drive_c;
    logic signed [TW:0]      diff_c;
    logic signed [TW:0]      step_c;
    logic signed [TW+1:0]    sum_c;
    logic signed [TW-1:0]    f_new_c;

    // Shared multiplier and twitch filter; channel chosen by the current MUL state
    always_comb begin
        mul_lat_c = (state_q == MUL1) ? lat1_q : lat2_q;
        f_cur_c   = (state_q == MUL1) ? torque1_q : torque2_q;
        product_c = PW'(mul_lat_c) * PW'(GAIN);
`ifdef TORQUE_GEN_SATURATE_EN
        drive_c   = (product_c > 36'd131071) ? F_MAX : TW'(product_c);
`else
        drive_c   = TW'(product_c);
`endif
        diff_c    = (TW + 1)'(drive_c) - (TW + 1)'(f_cur_c);
        step_c    = diff_c >>> TAU_SHIFT;
        sum_c     = (TW + 2)'(f_cur_c) + (TW + 2)'(step_c);
`ifdef TORQUE_GEN_SATURATE_EN
        if (sum_c < 0) begin
            f_new_c = '0;
        end else if (sum_c > 20'sd131071) begin
            f_new_c = F_MAX;
        end else begin
            f_new_c = TW'(sum_c);
        end
`else
        f_new_c   = TW'(sum_c);
`endif
    end

    // Next-state: FSM sequencing, spike counters and sticky flags
    always_comb begin
        state_d   = state_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
        lat1_d    = lat1_q;
        lat2_d    = lat2_q;
        f1n_d     = f1n_q;
        torque1_d = torque1_q;
        torque2_d = torque2_q;
        vcnt_d    = vcnt_q;
        valid_d   = 1'b0;
        cnt_sat_d = cnt_sat_q;
        overrun_d = overrun_q;

        // a spike at saturation is lost and flagged
        if (spike1) begin
            if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
            else                   cnt_sat_d = 1'b1;
        end
        if (spike2) begin
            if (cnt2_q != CNT_MAX) cnt2_d = cnt2_q + CNT_W'(1);
            else                   cnt_sat_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    // coincident spike belongs to the new window
                    lat1_d    = cnt1_q;
                    lat2_d    = cnt2_q;
                    cnt1_d    = CNT_W'(spike1);
                    cnt2_d    = CNT_W'(spike2);
                    cnt_sat_d = cnt_sat_q;
                    state_d   = MUL1;
                end
            end
            MUL1: begin
                f1n_d   = f_new_c;
                state_d = MUL2;
            end
            MUL2: begin
                torque1_d = f1n_q;
                torque2_d = f_new_c;
                vcnt_d    = '0;
                state_d   = STROBE;
            end
            STROBE: begin
                if (vcnt_q == VCW'(VALID_LEN)) begin
                    state_d = IDLE;
                end else begin
                    vcnt_d  = vcnt_q + VCW'(1);
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tick && (state_q != IDLE)) overrun_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge neuronClock or negedge neuronReset_n) begin
        if (!neuronReset_n) begin
            state_q   <= IDLE;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            lat1_q    <= '0;
            lat2_q    <= '0;
            f1n_q     <= '0;
            torque1_q <= '0;
            torque2_q <= '0;
            vcnt_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_sat_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            lat1_q    <= lat1_d;
            lat2_q    <= lat2_d;
            f1n_q     <= f1n_d;
            torque1_q <= torque1_d;
            torque2_q <= torque2_d;
            vcnt_q    <= vcnt_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            cnt_sat_q <= cnt_sat_d;
            overrun_q <= overrun_d;
        end
    end

    assign torque1      = torque1_q;
    assign torque2      = torque2_q;
    assign torque_valid = valid_q;
    assign busy         = busy_q;
    assign cnt_sat      = cnt_sat_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_torque_gen.sv
// Directed bench for torque_gen: spike windows, filter response, overrun,
// counter saturation (GAIN=256 instance) and mid-sequence reset.
module tb_torque_gen;

    localparam int VL  = 4;
    localparam int TAU = 4;

    logic clk;
    logic rst_n;
    logic tick, spike1, spike2;
    logic signed [17:0] torque1, torque2;
    logic torque_valid, busy, cnt_sat, overrun;

    logic tick_b, spike1_b, spike2_b;
    logic signed [17:0] b_torque1, b_torque2;
    logic b_valid, b_busy, b_cnt_sat, b_overrun;

    int checks = 0;
    int errors = 0;
    int sb_q[$];
    int m_f1, m_f2, m_c1, m_c2;

    torque_gen #(.CNT_W(10), .GAIN(64), .TAU_SHIFT(TAU), .VALID_LEN(VL)) u_dut (
        .neuronClock(clk), .neuronReset_n(rst_n), .tick(tick),
        .spike1(spike1), .spike2(spike2),
        .torque1(torque1), .torque2(torque2), .torque_valid(torque_valid),
        .busy(busy), .cnt_sat(cnt_sat), .overrun(overrun)
    );

    torque_gen #(.CNT_W(10), .GAIN(256), .TAU_SHIFT(TAU), .VALID_LEN(VL)) u_dut_b (
        .neuronClock(clk), .neuronReset_n(rst_n), .tick(tick_b),
        .spike1(spike1_b), .spike2(spike2_b),
        .torque1(b_torque1), .torque2(b_torque2), .torque_valid(b_valid),
        .busy(b_busy), .cnt_sat(b_cnt_sat), .overrun(b_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference filter step in plain integer arithmetic
    function automatic int filt(input int f, input int cnt, input int gain);
        longint p;
        int drive;
        int s;
        p = longint'(cnt) * longint'(gain);
`ifdef TORQUE_GEN_SATURATE_EN
        drive = (p > 131071) ? 131071 : int'(p);
`else
        drive = int'(p % 262144);
        if (drive >= 131072) drive = drive - 262144;
`endif
        s = f + ((drive - f) >>> TAU);
`ifdef TORQUE_GEN_SATURATE_EN
        if (s < 0) s = 0;
        if (s > 131071) s = 131071;
`else
        s = ((s % 262144) + 262144) % 262144;
        if (s >= 131072) s = s - 262144;
`endif
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_spikes(input int n1, input int n2);
        int n;
        n = (n1 > n2) ? n1 : n2;
        for (int i = 0; i < n; i++) begin
            spike1 = (i < n1);
            spike2 = (i < n2);
            if (i < n1 && m_c1 < 1023) m_c1++;
            if (i < n2 && m_c2 < 1023) m_c2++;
            step();
        end
        spike1 = 1'b0;
        spike2 = 1'b0;
    endtask

    // One window on the main DUT: optional coincident spike1, optional extra
    // tick in cycle 2, optional reset during cycle 5.
    task automatic do_window(input bit s1t, input bit xt, input bit rst5);
        int e1, e2;
        m_f1 = filt(m_f1, m_c1, 64);
        m_f2 = filt(m_f2, m_c2, 64);
        sb_q.push_back(m_f1);
        sb_q.push_back(m_f2);
        m_c1 = s1t ? 1 : 0;
        m_c2 = 0;
        tick = 1'b1;
        spike1 = s1t;
        step();                                   // cycle 1
        tick = 1'b0;
        spike1 = 1'b0;
        check("busy_c1", 32'(busy), 32'd1);
        step();                                   // cycle 2
        if (xt) tick = 1'b1;
        step();                                   // cycle 3
        tick = 1'b0;
        if (xt) m_c1 = m_c1;                      // ignored tick leaves counters intact
        e1 = sb_q.pop_front();
        e2 = sb_q.pop_front();
        check("torque1_c3", 32'(torque1), 32'(e1));
        check("torque2_c3", 32'(torque2), 32'(e2));
        check("valid_c3", 32'(torque_valid), 32'd0);
        if (rst5) begin
            step();                               // cycle 4
            step();                               // cycle 5
            check("valid_c5", 32'(torque_valid), 32'd1);
            rst_n = 1'b0;
            #1;
            check("rst_valid", 32'(torque_valid), 32'd0);
            check("rst_torque1", 32'(torque1), 32'd0);
            check("rst_torque2", 32'(torque2), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_overrun", 32'(overrun), 32'd0);
            step();
            rst_n = 1'b1;
            m_f1 = 0; m_f2 = 0; m_c1 = 0; m_c2 = 0;
        end else begin
            for (int k = 1; k <= VL; k++) begin
                step();
                check("valid_hi", 32'(torque_valid), 32'd1);
                check("busy_hi", 32'(busy), 32'd1);
                if (k == 1) check("torque1_hold", 32'(torque1), 32'(e1));
            end
            step();                               // cycle 4+VL
            check("valid_end", 32'(torque_valid), 32'd0);
            check("busy_end", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int e;
        rst_n = 1'b0;
        tick = 1'b0; spike1 = 1'b0; spike2 = 1'b0;
        tick_b = 1'b0; spike1_b = 1'b0; spike2_b = 1'b0;
        m_f1 = 0; m_f2 = 0; m_c1 = 0; m_c2 = 0;
        #12;
        check("rst_torque1", 32'(torque1), 32'd0);
        check("rst_torque2", 32'(torque2), 32'd0);
        check("rst_valid", 32'(torque_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt_sat", 32'(cnt_sat), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step();

        // three windows of 16 flexor spikes: 64, 124, 180
        pulse_spikes(16, 0);
        do_window(1'b0, 1'b0, 1'b0);
        check("torque1_w1_abs", 32'(torque1), 32'd64);
        pulse_spikes(16, 0);
        do_window(1'b0, 1'b0, 1'b0);
        pulse_spikes(16, 0);
        do_window(1'b0, 1'b0, 1'b0);
        check("torque1_w3_abs", 32'(torque1), 32'd180);
        check("cnt_sat_none", 32'(cnt_sat), 32'd0);

        // zero-spike decay, mixed channels
        do_window(1'b0, 1'b0, 1'b0);
        pulse_spikes(5, 40);
        do_window(1'b0, 1'b0, 1'b0);

        // coincident spike plus tick while busy
        check("overrun_pre", 32'(overrun), 32'd0);
        do_window(1'b1, 1'b1, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_strobe", 32'(torque_valid), 32'd0);
        end
        do_window(1'b0, 1'b0, 1'b0);              // carries the coincident spike

        // reset in cycle 5, then normal operation resumes
        pulse_spikes(16, 0);
        do_window(1'b0, 1'b0, 1'b1);
        step();
        pulse_spikes(16, 0);
        do_window(1'b0, 1'b0, 1'b0);
        check("torque1_after_rst", 32'(torque1), 32'd64);
        do_window(1'b0, 1'b0, 1'b0);
        check("torque1_decay_abs", 32'(torque1), 32'd60);

        // counter saturation on the GAIN=256 instance
        for (int i = 0; i < 1500; i++) begin
            spike2_b = 1'b1;
            step();
        end
        spike2_b = 1'b0;
        check("b_cnt_sat", 32'(b_cnt_sat), 32'd1);
        sb_q.push_back(filt(0, 1023, 256));
        tick_b = 1'b1;
        step();
        tick_b = 1'b0;
        step();
        step();
        e = sb_q.pop_front();
        check("b_torque2", 32'(b_torque2), 32'(e));
`ifdef TORQUE_GEN_SATURATE_EN
        check("b_torque2_abs", 32'(b_torque2), 32'd8191);
`else
        check("b_torque2_abs", 32'(b_torque2), -32'sd16);
`endif
        check("b_torque1", 32'(b_torque1), 32'd0);
        step();
        check("b_valid", 32'(b_valid), 32'd1);
        for (int i = 0; i < VL + 2; i++) step();
        check("b_busy_end", 32'(b_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
